// File: rtl/static_group_router_pkg.sv
// Shared types, constants and helpers for static_group_router and its watchdog.
package static_group_router_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   // Read data returned with an error response (unmapped group or timeout).
   localparam int ERR_RDATA = 0;

   function automatic int gid_width(input int num_groups);
      return (num_groups > 1) ? $clog2(num_groups) : 1;
   endfunction

endpackage

// File: rtl/static_group_router_wdog.sv
// REQ-phase watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count would reach LIMIT.
module static_group_router_wdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry is flagged in the LIMIT-th REQ cycle so RESP follows immediately.
   assign expired_o = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/static_group_router.sv
// Registered router from the static register port to NUM_GROUPS register groups.
// Define STATIC_GROUP_ROUTER_TIMEOUT_EN to add a REQ-phase watchdog timeout.
module static_group_router
   import static_group_router_pkg::*;
#(
   parameter int NUM_GROUPS     = 3,
   parameter int ADDR_W         = 20,
   parameter int DATA_W         = 32,
   parameter int GID_W          = gid_width(NUM_GROUPS),
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         scan_id,
   input  logic                         static_wen,
   input  logic                         static_ren,
   input  logic [ADDR_W-1:0]            static_addr,
   input  logic [DATA_W-1:0]            static_wdata,
   output logic [DATA_W-1:0]            static_rdata,
   output logic                         static_ready,
   output logic                         static_err,
   output logic                         static_busy,
   output logic [NUM_GROUPS-1:0]        scan_id_g,
   output logic [NUM_GROUPS-1:0]        static_wen_g,
   output logic [NUM_GROUPS-1:0]        static_ren_g,
   output logic [NUM_GROUPS*ADDR_W-1:0] static_addr_g,
   output logic [NUM_GROUPS*DATA_W-1:0] static_wdata_g,
   input  logic [NUM_GROUPS*DATA_W-1:0] static_rdata_g,
   input  logic [NUM_GROUPS-1:0]        static_ready_g
);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [GID_W-1:0]        gid_q, gid_d;
   logic                    wr_q, wr_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [NUM_GROUPS-1:0]   scan_q, scan_d;

   logic [GID_W-1:0]        gid_in;
   logic                    gid_mapped;
   logic                    wdog_expired;

   assign gid_in     = static_addr[ADDR_W-1 -: GID_W];
   assign gid_mapped = {{(32-GID_W){1'b0}}, gid_in} < 32'(NUM_GROUPS);

`ifdef STATIC_GROUP_ROUTER_TIMEOUT_EN
   static_group_router_wdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (state_q != REQ),
      .enable_i (state_q == REQ),
      .expired_o(wdog_expired)
   );
`else
   assign wdog_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gid_d   = gid_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      scan_d  = scan_q;
      unique case (state_q)
         IDLE: begin
            if (static_wen || static_ren) begin
               addr_d  = static_addr;
               wdata_d = static_wdata;
               gid_d   = gid_in;
               wr_d    = static_wen;
               if (gid_mapped) begin
                  state_d        = REQ;
                  scan_d[gid_in] = scan_id;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = DATA_W'(ERR_RDATA);
               end
            end
         end
         REQ: begin
            // Group ready takes precedence over a watchdog expiry in the same cycle.
            if (static_ready_g[gid_q]) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = static_rdata_g[gid_q*DATA_W +: DATA_W];
            end else if (wdog_expired) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = DATA_W'(ERR_RDATA);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         gid_q   <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         scan_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         gid_q   <= gid_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         scan_q  <= scan_d;
      end
   end

   assign static_rdata = rdata_q;
   assign static_err   = err_q;
   assign static_ready = (state_q == RESP);
   assign static_busy  = (state_q != IDLE);
   assign scan_id_g    = scan_q;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_fanout
      logic sel;
      assign sel                                = (state_q == REQ) && (gid_q == GID_W'(g));
      assign static_wen_g[g]                    = sel && wr_q;
      assign static_ren_g[g]                    = sel && !wr_q;
      assign static_addr_g[g*ADDR_W +: ADDR_W]  = sel ? addr_q : '0;
      assign static_wdata_g[g*DATA_W +: DATA_W] = sel ? wdata_q : '0;
   end

endmodule

// File: tb/tb_static_group_router.sv
// Directed bench for static_group_router with a queue-based response scoreboard.
module tb_static_group_router;

   localparam int NG = 3;
   localparam int AW = 20;
   localparam int DW = 32;
`ifdef STATIC_GROUP_ROUTER_TIMEOUT_EN
   localparam int TO = 8;
   localparam int EXP_PULSES = 7;
`else
   localparam int TO = 255;
   localparam int EXP_PULSES = 5;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              scan_id;
   logic              static_wen;
   logic              static_ren;
   logic [AW-1:0]     static_addr;
   logic [DW-1:0]     static_wdata;
   logic [DW-1:0]     static_rdata;
   logic              static_ready;
   logic              static_err;
   logic              static_busy;
   logic [NG-1:0]     scan_id_g;
   logic [NG-1:0]     static_wen_g;
   logic [NG-1:0]     static_ren_g;
   logic [NG*AW-1:0]  static_addr_g;
   logic [NG*DW-1:0]  static_wdata_g;
   logic [NG*DW-1:0]  static_rdata_g;
   logic [NG-1:0]     static_ready_g;

   int checks = 0;
   int errors = 0;
   int ready_cnt = 0;
   logic [DW:0] exp_q[$];

   static_group_router #(
      .NUM_GROUPS(NG), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .scan_id(scan_id),
      .static_wen(static_wen), .static_ren(static_ren),
      .static_addr(static_addr), .static_wdata(static_wdata),
      .static_rdata(static_rdata), .static_ready(static_ready),
      .static_err(static_err), .static_busy(static_busy),
      .scan_id_g(scan_id_g), .static_wen_g(static_wen_g), .static_ren_g(static_ren_g),
      .static_addr_g(static_addr_g), .static_wdata_g(static_wdata_g),
      .static_rdata_g(static_rdata_g), .static_ready_g(static_ready_g)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard monitor: every upstream ready pulse must match the queue head
   always @(negedge clk) begin
      if (!rst && static_ready) begin
         ready_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: got rdata=%0h err=%0b, required no pulse",
                     static_rdata, static_err);
         end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            if ({static_err, static_rdata} !== e) begin
               errors++;
               $display("FAIL response: got err=%0b rdata=%0h, required err=%0b rdata=%0h",
                        static_err, static_rdata, e[DW], e[DW-1:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // driver: request held one cycle, sampled at the following edge (edge 0)
   task automatic issue(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic s);
      @(posedge clk); #1;
      static_wen = w; static_ren = r; static_addr = a; static_wdata = d; scan_id = s;
      @(posedge clk); #1;
      static_wen = 1'b0; static_ren = 1'b0;
   endtask

   // driver + group model: group answers in cycle k after the request edge
   task automatic mapped_req(input logic w, input logic r, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic s, input int grp,
                             input int k, input logic [DW-1:0] rd);
      logic [NG-1:0]    one_hot;
      logic [NG*AW-1:0] ea;
      logic [NG*DW-1:0] ed;
      one_hot = '0; one_hot[grp] = 1'b1;
      ea = '0; ea[grp*AW +: AW] = a;
      ed = '0; ed[grp*DW +: DW] = d;
      issue(w, r, a, d, s);
      chk("strobe_wen", static_wen_g, w ? one_hot : {NG{1'b0}});
      chk("strobe_ren", static_ren_g, w ? {NG{1'b0}} : one_hot);
      chk("addr_g", static_addr_g, ea);
      chk("wdata_g", static_wdata_g, ed);
      chk("busy_set", static_busy, 1'b1);
      for (int i = 1; i < k; i++) begin
         @(posedge clk); #1;
      end
      chk("ready_early", static_ready, 1'b0);
      exp_q.push_back({1'b0, rd});
      static_ready_g[grp] = 1'b1;
      static_rdata_g[grp*DW +: DW] = rd;
      @(posedge clk); #1;
      static_ready_g = '0;
      static_rdata_g = '0;
      chk("ready_latency", static_ready, 1'b1);
      chk("strobe_drop", {static_wen_g, static_ren_g}, '0);
      @(posedge clk); #1;
      chk("busy_clear", static_busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; scan_id = 1'b0; static_wen = 1'b0; static_ren = 1'b0;
      static_addr = '0; static_wdata = '0; static_rdata_g = '0; static_ready_g = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", static_ready, 1'b0);
      chk("rst_busy", static_busy, 1'b0);
      chk("rst_err", static_err, 1'b0);
      chk("rst_rdata", static_rdata, '0);
      chk("rst_scan", scan_id_g, '0);
      chk("rst_strobes", {static_wen_g, static_ren_g}, '0);
      rst = 1'b0;

      // read group 1, group answers 3 cycles after the strobe appears
      mapped_req(1'b0, 1'b1, 20'h40010, 32'h0000_0000, 1'b1, 1, 4, 32'hCAFE_0001);
      chk("scan_after_read", scan_id_g, 3'b010);

      // write group 0, immediate answer; write still captures group rdata
      mapped_req(1'b1, 1'b0, 20'h00004, 32'h1234_5678, 1'b1, 0, 1, 32'hDEAD_0000);
      chk("scan_after_write", scan_id_g, 3'b011);

      // unmapped group 3
      issue(1'b0, 1'b1, 20'hC0000, 32'h0, 1'b0);
      exp_q.push_back({1'b1, 32'h0});
      chk("unmapped_ready", static_ready, 1'b1);
      chk("unmapped_strobes", {static_wen_g, static_ren_g}, '0);
      chk("unmapped_scan", scan_id_g, 3'b011);
      @(posedge clk); #1;
      chk("unmapped_idle", static_busy, 1'b0);

      // busy drop: second request and a foreign group ready during REQ
      issue(1'b0, 1'b1, 20'h80020, 32'h0, 1'b0);
      static_wen = 1'b1; static_addr = 20'h40000; static_wdata = 32'hFFFF_FFFF;
      scan_id = 1'b0; static_ready_g[0] = 1'b1; static_rdata_g[DW-1:0] = 32'h9999_9999;
      @(posedge clk); #1;
      static_wen = 1'b0; static_ready_g = '0; static_rdata_g = '0;
      chk("drop_wen", static_wen_g, 3'b000);
      chk("drop_ren", static_ren_g, 3'b100);
      chk("drop_addr", static_addr_g[2*AW +: AW], 20'h80020);
      chk("drop_ready", static_ready, 1'b0);
      exp_q.push_back({1'b0, 32'h2222_2222});
      static_ready_g[2] = 1'b1; static_rdata_g[2*DW +: DW] = 32'h2222_2222;
      @(posedge clk); #1;
      static_ready_g = '0; static_rdata_g = '0;
      chk("drop_resp", static_ready, 1'b1);
      @(posedge clk); #1;
      chk("drop_idle", static_busy, 1'b0);
      chk("drop_scan", scan_id_g, 3'b011);

      // simultaneous wen+ren acts as a write
      mapped_req(1'b1, 1'b1, 20'h80020, 32'hA5A5_A5A5, 1'b1, 2, 2, 32'h0BAD_F00D);
      chk("scan_after_both", scan_id_g, 3'b111);

      // reset asserted while in REQ
      issue(1'b0, 1'b1, 20'h40010, 32'h0, 1'b0);
      chk("pre_rst_strobe", static_ren_g, 3'b010);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_strobes", {static_wen_g, static_ren_g}, '0);
      chk("mid_rst_busy", static_busy, 1'b0);
      chk("mid_rst_scan", scan_id_g, '0);
      chk("mid_rst_rdata", static_rdata, '0);
      chk("mid_rst_addr", static_addr_g, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_ready", static_ready, 1'b0);

`ifdef STATIC_GROUP_ROUTER_TIMEOUT_EN
      // group never answers: error response after 8 REQ cycles
      issue(1'b0, 1'b1, 20'h00008, 32'h0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      chk("to_strobe_held", static_ren_g, 3'b001);
      chk("to_not_yet", static_ready, 1'b0);
      exp_q.push_back({1'b1, 32'h0});
      @(posedge clk); #1;
      chk("to_ready", static_ready, 1'b1);
      chk("to_strobe_drop", static_ren_g, 3'b000);
      @(posedge clk); #1;
      // answer in the expiry cycle: ready wins
      mapped_req(1'b0, 1'b1, 20'h00008, 32'h0, 1'b0, 0, 8, 32'h5555_AAAA);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      chk("pulse_count", ready_cnt, EXP_PULSES);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
